// File: rtl/uart_seq_pkg.sv
// Shared types and default widths for the UART TX byte sequencer.
package uart_seq_pkg;

  localparam int unsigned DefDataWidth    = 8;
  localparam int unsigned DefBufAddrWidth = 8;
  localparam int unsigned DefGapWidth     = 16;
  localparam int unsigned SentCntWidth    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitDone,
    StGap
  } seq_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with synchronous flush, registered level/full/empty
// and a sticky overflow flag.
module uart_byte_fifo
  import uart_seq_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned AddrWidth = DefBufAddrWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic [AddrWidth:0]   level_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 overflow_o
);

  localparam int unsigned Depth  = 2 ** AddrWidth;
  localparam int unsigned LevelW = AddrWidth + 1;
  localparam logic [AddrWidth:0] MaxLevel = LevelW'(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   level_q, level_d;
  logic                 full_q, empty_q;
  logic                 ovf_q, ovf_d;
  logic                 push_ok, pop_ok;

  // Flush dominates both ports; a push into a full FIFO is dropped.
  assign push_ok = push_i && !full_q && !flush_i;
  assign pop_ok  = pop_i && !empty_q && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AddrWidth'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AddrWidth'(1);
      end
      if (push_i && full_q) begin
        ovf_d = 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level_d = level_q + LevelW'(1);
      end else if (!push_ok && pop_ok) begin
        level_d = level_q - LevelW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == MaxLevel);
      empty_q  <= (level_d == '0);
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/uart_tx_sequencer.sv
// Pops bytes from a FIFO and issues one-cycle start commands to tx_uart,
// waiting for each frame's done edge plus a programmable idle gap.
module uart_tx_sequencer
  import uart_seq_pkg::*;
#(
  parameter int unsigned G_DATA_WIDTH        = DefDataWidth,
  parameter int unsigned G_BUFFER_ADDR_WIDTH = DefBufAddrWidth,
  parameter int unsigned G_GAP_WIDTH         = DefGapWidth
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_wr_en,
  input  logic [G_DATA_WIDTH-1:0]        i_wr_data,
  input  logic                           i_flush,
  input  logic                           i_enable,
  input  logic [G_GAP_WIDTH-1:0]         i_gap_cycles,
  output logic                           o_start_tx,
  output logic [G_DATA_WIDTH-1:0]        o_tx_data,
  input  logic                           i_tx_done,
  output logic [G_BUFFER_ADDR_WIDTH:0]   o_level,
  output logic                           o_full,
  output logic                           o_empty,
  output logic                           o_overflow,
  output logic                           o_busy,
  output logic [SentCntWidth-1:0]        o_sent_cnt
);

  seq_state_e                state_q, state_d;
  logic [G_GAP_WIDTH-1:0]    gap_q, gap_d;
  logic [SentCntWidth-1:0]   sent_q, sent_d;
  logic [G_DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                      done_prev_q;
  logic                      done_rise;
  logic                      pop;
  logic [G_DATA_WIDTH-1:0]   fifo_rd_data;
  logic                      fifo_empty;

  uart_byte_fifo #(
    .DataWidth(G_DATA_WIDTH),
    .AddrWidth(G_BUFFER_ADDR_WIDTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .push_i    (i_wr_en),
    .wr_data_i (i_wr_data),
    .pop_i     (pop),
    .flush_i   (i_flush),
    .rd_data_o (fifo_rd_data),
    .level_o   (o_level),
    .full_o    (o_full),
    .empty_o   (fifo_empty),
    .overflow_o(o_overflow)
  );

  // A done level that was already high before WAIT_DONE is not a completion.
  assign done_rise = i_tx_done && !done_prev_q;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    sent_d    = sent_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_enable && !fifo_empty && !i_flush) begin
          pop       = 1'b1;
          tx_data_d = fifo_rd_data;
          state_d   = StStart;
        end
      end
      StStart: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (done_rise) begin
          sent_d = sent_q + SentCntWidth'(1);
          if (i_gap_cycles == '0) begin
            state_d = StIdle;
          end else begin
            gap_d   = i_gap_cycles;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q <= G_GAP_WIDTH'(1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - G_GAP_WIDTH'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gap_q       <= '0;
      sent_q      <= '0;
      tx_data_q   <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      sent_q      <= sent_d;
      tx_data_q   <= tx_data_d;
      done_prev_q <= i_tx_done;
    end
  end

  assign o_start_tx = (state_q == StStart);
  assign o_busy     = (state_q != StIdle);
  assign o_tx_data  = tx_data_q;
  assign o_empty    = fifo_empty;
  assign o_sent_cnt = sent_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench: byte-queue reference model plus a behavioural tx_uart.
module tb_uart_tx_sequencer;

  localparam int Depth = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        flush = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] gap = '0;
  logic        tx_done = 1'b0;
  logic        start_tx;
  logic [7:0]  tx_data;
  logic [8:0]  level;
  logic        full, empty, ovf, busy;
  logic [15:0] sent;

  uart_tx_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .i_flush     (flush),
    .i_enable    (enable),
    .i_gap_cycles(gap),
    .o_start_tx  (start_tx),
    .o_tx_data   (tx_data),
    .i_tx_done   (tx_done),
    .o_level     (level),
    .o_full      (full),
    .o_empty     (empty),
    .o_overflow  (ovf),
    .o_busy      (busy),
    .o_sent_cnt  (sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  byte unsigned exp_q[$];
  int          exp_sent = 0;
  bit          exp_ovf = 1'b0;
  int          n_starts = 0;
  int          n_edges = 0;
  int          n_extra = 0;
  int          start_cycs[$];
  int          edge_cycs[$];
  int          tx_delay = 0;
  bit          tx_active = 1'b0;
  bit          prev_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every start pulse must carry the oldest accepted byte not yet sent.
  always @(negedge clk) begin
    if (rst_n && start_tx) begin
      n_starts++;
      start_cycs.push_back(cyc);
      if (prev_start || exp_q.size() == 0) n_extra++;
      else chk("start_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
    prev_start = rst_n && start_tx;
  end

  // Behavioural tx_uart: done rises some cycles after a start, held for two cycles.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (rst_n && start_tx) begin
        tx_active = 1'b1;
        d = (tx_delay != 0) ? tx_delay : int'($urandom_range(2, 6));
        repeat (d) @(posedge clk);
        #1 tx_done = 1'b1;
        edge_cycs.push_back(cyc);
        n_edges++;
        exp_sent++;
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b0;
        tx_active = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk);
    if (exp_q.size() < Depth) exp_q.push_back(b);
    else exp_ovf = 1'b1;
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (k < 6000 && (exp_q.size() != 0 || busy || tx_active)) begin
      step(1);
      k++;
    end
    chk({tag, "_in_time"}, {31'd0, k < 6000}, 32'd1);
  endtask

  task automatic wait_starts(input int target);
    int k = 0;
    while (k < 200 && n_starts < target) begin
      step(1);
      k++;
    end
    chk("start_in_time", n_starts, target);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, {31'd0, start_tx}, 32'd0);
    chk({tag, "_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_level"}, {23'd0, level}, 32'd0);
    chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    chk({tag, "_full"}, {31'd0, full}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sent"}, {16'd0, sent}, 32'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, e0, en_c;
    step(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    step(2);

    // Basic back-to-back stream with no gap.
    gap = 16'd0;
    enable = 1'b1;
    push(8'hA5);
    push(8'h3C);
    push(8'hFF);
    wait_idle("basic");
    chk("basic_sent", {16'd0, sent}, 32'd3);
    chk("basic_starts", n_starts, 3);
    chk("basic_empty", {31'd0, empty}, 32'd1);
    chk("basic_level", {23'd0, level}, 32'd0);

    // Enable latency and a 10-cycle gap.
    enable = 1'b0;
    gap = 16'd10;
    start_cycs.delete();
    edge_cycs.delete();
    push(8'($urandom));
    push(8'($urandom));
    step(5);
    chk("disabled_no_start", start_cycs.size(), 0);
    chk("disabled_level", {23'd0, level}, 32'd2);
    en_c = cyc;
    enable = 1'b1;
    wait_idle("gap");
    chk("enable_latency", start_cycs[0], en_c + 1);
    chk("gap_spacing", start_cycs[1] - edge_cycs[0], 12);

    // Fill to capacity and overflow.
    enable = 1'b0;
    gap = 16'd0;
    for (int i = 0; i < Depth; i++) push(8'($urandom));
    push(8'h11);
    step(1);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_level", {23'd0, level}, 32'd256);
    chk("fill_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
    enable = 1'b1;
    wait_idle("drain");
    chk("drain_sent", {16'd0, sent}, 32'd261);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    exp_ovf = 1'b0;
    chk("flush_clears_ovf", {31'd0, ovf}, {31'd0, exp_ovf});

    // Flush during WAIT_DONE with four bytes queued and a same-cycle push.
    tx_delay = 20;
    n0 = n_starts;
    push(8'h55);
    wait_starts(n0 + 1);
    for (int i = 0; i < 4; i++) push(8'($urandom));
    chk("preflush_level", {23'd0, level}, 32'd4);
    wr_en = 1'b1;
    wr_data = 8'($urandom);
    flush = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1 wr_en = 1'b0;
    flush = 1'b0;
    step(1);
    chk("flush_level", {23'd0, level}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    wait_idle("flush");
    step(10);
    chk("flush_no_more_starts", n_starts, n0 + 1);
    chk("flush_frame_done", {16'd0, sent}, 32'd262);
    tx_delay = 0;

    // Drop enable mid-frame.
    gap = 16'd2;
    n0 = n_starts;
    push(8'($urandom));
    push(8'($urandom));
    push(8'($urandom));
    wait_starts(n0 + 1);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    step(60);
    chk("disable_one_frame", n_starts, n0 + 1);
    chk("disable_level", {23'd0, level}, 32'd2);
    chk("disable_idle", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    wait_idle("reenable");
    chk("reenable_starts", n_starts, n0 + 3);

    // Random traffic with enable and gap changes.
    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) push(8'($urandom));
      else if (r < 8) step(int'($urandom_range(1, 8)));
      else begin
        enable = 1'($urandom);
        gap = 16'($urandom_range(0, 4));
        step(1);
      end
    end
    enable = 1'b1;
    wait_idle("random");
    chk("random_sent", {16'd0, sent}, 32'(exp_sent % 65536));
    chk("random_level", {23'd0, level}, 32'd0);
    chk("no_extra_starts", n_extra, 0);

    // Asynchronous reset during GAP.
    gap = 16'd20;
    e0 = n_edges;
    push(8'($urandom));
    push(8'($urandom));
    begin
      int k = 0;
      while (k < 200 && n_edges == e0) begin
        step(1);
        k++;
      end
    end
    step(4);
    chk("in_gap_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    exp_q.delete();
    exp_sent = 0;
    exp_ovf = 1'b0;
    step(2);
    rst_n = 1'b1;
    n0 = n_starts;
    step(40);
    chk("post_rst_no_start", n_starts, n0);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    push(8'($urandom));
    wait_idle("post_rst");
    chk("post_rst_sent", {16'd0, sent}, 32'(exp_sent));
    chk("final_no_extra", n_extra, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
